// File: rtl/heap_pkg.sv
// rtl/heap_pkg.sv - shared heap opcodes, client opcodes and arbiter FSM states
//
// Purpose: common definitions for the heap access front-end and its users.
// Ports: none (package).
package heap_pkg;

    // Heap command-port opcodes (5-bit operation field of heap_module).
    localparam logic [4:0] HP_OP_INIT = 5'd0;
    localparam logic [4:0] HP_OP_PUSH = 5'd1;
    localparam logic [4:0] HP_OP_POP  = 5'd2;
    localparam logic [4:0] HP_OP_SORT = 5'd3;

    // Client request opcode carried on req_op.
    localparam logic CLIENT_OP_PUSH = 1'b0;
    localparam logic CLIENT_OP_POP  = 1'b1;

    // Physical heap depth; the arbiter caps occupancy one below this so the
    // heap's size counter never wraps.
    localparam int MAX_HEAP_SIZE = 32;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CHECK,
        S_PUSH_ISSUE,
        S_POP_PEEK,
        S_POP_ISSUE,
        S_RESP,
        S_FLUSH
    } arb_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin winner select
//
// Purpose: pick the first asserted request at or after ptr, wrapping.
// Ports:
//   req    in  NREQ   request vector
//   ptr    in  IDX_W  highest-priority index for this search
//   grant  out NREQ   one-hot grant (all zero when no request)
//   winner out IDX_W  index of the granted request
module rr_arbiter #(
    parameter int NREQ  = 4,
    parameter int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0]  req,
    input  logic [IDX_W-1:0] ptr,
    output logic [NREQ-1:0]  grant,
    output logic [IDX_W-1:0] winner
);

    always_comb begin
        int idx;
        idx    = 0;
        grant  = '0;
        winner = '0;
        // Walk offsets from farthest to nearest so the nearest requester
        // to ptr is the last (and therefore winning) assignment.
        for (int k = NREQ - 1; k >= 0; k--) begin
            idx = (int'(ptr) + k) % NREQ;
            if (req[idx]) begin
                grant      = '0;
                grant[idx] = 1'b1;
                winner     = IDX_W'(idx);
            end
        end
    end

endmodule

// File: rtl/heap_access_arbiter.sv
// rtl/heap_access_arbiter.sv - multi-client push/pop front-end for heap_module
//
// Purpose: round-robin arbitration of client push/pop requests, sequencing
// each onto the heap's single-cycle command port, plus heap flush (INIT).
// Ports:
//   clk, reset                       clock, async active-high reset
//   req_valid/req_op/req_data        per-client request (op 0 push, 1 pop)
//   req_ready                        one-hot accept strobe
//   rsp_valid/rsp_data/rsp_err       one-hot response strobe, pop data, error
//   flush_req/flush_done             level flush request, completion pulse
//   busy                             FSM not idle
//   hp_enable/hp_operation/
//   hp_input_value/hp_index          heap command port
//   hp_output_value/hp_heap_size     heap read data and occupancy
module heap_access_arbiter
    import heap_pkg::*;
#(
    parameter int NREQ   = 4,
    parameter int DATA_W = 32,
    parameter int SIZE_W = 5,
    parameter int CAP    = MAX_HEAP_SIZE - 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NREQ-1:0]        req_valid,
    input  logic [NREQ-1:0]        req_op,
    input  logic [NREQ*DATA_W-1:0] req_data,
    output logic [NREQ-1:0]        req_ready,
    output logic [NREQ-1:0]        rsp_valid,
    output logic [DATA_W-1:0]      rsp_data,
    output logic                   rsp_err,
    input  logic                   flush_req,
    output logic                   flush_done,
    output logic                   busy,
    output logic                   hp_enable,
    output logic [4:0]             hp_operation,
    output logic [DATA_W-1:0]      hp_input_value,
    output logic [4:0]             hp_index,
    input  logic [DATA_W-1:0]      hp_output_value,
    input  logic [SIZE_W-1:0]      hp_heap_size
);

    localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [SIZE_W-1:0] CAP_LIM = SIZE_W'(CAP);

    arb_state_t        state, state_nx;
    logic [IDX_W-1:0]  ptr, winner, grant_id;
    logic [NREQ-1:0]   grant;
    logic              accept;
    logic              op_q;
    logic [DATA_W-1:0] data_q, value_q, rsp_data_q;
    logic              err_q;

    rr_arbiter #(.NREQ(NREQ), .IDX_W(IDX_W)) u_rr (
        .req    (req_valid),
        .ptr    (ptr),
        .grant  (grant),
        .winner (winner)
    );

    // Flush outranks clients; no accept strobe while reset is held.
    assign accept    = !reset && (state == S_IDLE) && !flush_req && (|req_valid);
    assign req_ready = accept ? grant : '0;

    assign rsp_valid      = (state == S_RESP) ? (NREQ'(1) << grant_id) : '0;
    assign rsp_data       = rsp_data_q;
    assign rsp_err        = err_q;
    assign busy           = (state != S_IDLE);
    assign hp_input_value = value_q;
    assign hp_index       = 5'd0;

    always_comb begin
        state_nx     = state;
        hp_enable    = 1'b0;
        hp_operation = HP_OP_INIT;
        unique case (state)
            S_IDLE: begin
                if (flush_req)        state_nx = S_FLUSH;
                else if (|req_valid)  state_nx = S_CHECK;
            end
            S_CHECK: begin
                if (op_q == CLIENT_OP_PUSH)
                    state_nx = (hp_heap_size >= CAP_LIM) ? S_RESP : S_PUSH_ISSUE;
                else
                    state_nx = (hp_heap_size == '0) ? S_RESP : S_POP_PEEK;
            end
            S_PUSH_ISSUE: begin
                hp_enable    = 1'b1;
                hp_operation = HP_OP_PUSH;
                state_nx     = S_RESP;
            end
            // Gives the heap's registered read port a cycle to present the top.
            S_POP_PEEK:   state_nx = S_POP_ISSUE;
            S_POP_ISSUE: begin
                hp_enable    = 1'b1;
                hp_operation = HP_OP_POP;
                state_nx     = S_RESP;
            end
            S_RESP:       state_nx = S_IDLE;
            S_FLUSH: begin
                hp_enable    = 1'b1;
                hp_operation = HP_OP_INIT;
                state_nx     = S_IDLE;
            end
            default:      state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= S_IDLE;
            ptr        <= '0;
            grant_id   <= '0;
            op_q       <= CLIENT_OP_PUSH;
            data_q     <= '0;
            value_q    <= '0;
            rsp_data_q <= '0;
            err_q      <= 1'b0;
            flush_done <= 1'b0;
        end else begin
            state      <= state_nx;
            flush_done <= (state == S_FLUSH);
            if (accept) begin
                grant_id   <= winner;
                op_q       <= req_op[winner];
                data_q     <= req_data[winner*DATA_W +: DATA_W];
                rsp_data_q <= '0;
                err_q      <= 1'b0;
                ptr        <= (int'(winner) == NREQ - 1) ? '0 : winner + 1'b1;
            end
            if (state == S_CHECK) begin
                if (state_nx == S_RESP)       err_q   <= 1'b1;
                // Heap input only changes when a push is actually issued.
                if (state_nx == S_PUSH_ISSUE) value_q <= data_q;
            end
            if (state == S_POP_ISSUE) rsp_data_q <= hp_output_value;
        end
    end

endmodule

// File: tb/tb_heap_access_arbiter.sv
// tb/tb_heap_access_arbiter.sv - self-checking bench for heap_access_arbiter
module tb_heap_access_arbiter;
    import heap_pkg::*;

    localparam int NREQ   = 4;
    localparam int DATA_W = 32;
    localparam int SIZE_W = 5;
    localparam int CAP    = 31;

    logic                   clk = 1'b0;
    logic                   reset;
    logic [NREQ-1:0]        req_valid, req_op, req_ready, rsp_valid;
    logic [NREQ*DATA_W-1:0] req_data;
    logic [DATA_W-1:0]      rsp_data, hp_input_value, hp_output_value;
    logic                   rsp_err, flush_req, flush_done, busy, hp_enable;
    logic [4:0]             hp_operation, hp_index;
    logic [SIZE_W-1:0]      hp_heap_size;

    always #5 clk = ~clk;

    heap_access_arbiter #(.NREQ(NREQ), .DATA_W(DATA_W), .SIZE_W(SIZE_W), .CAP(CAP)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_op(req_op), .req_data(req_data), .req_ready(req_ready),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err),
        .flush_req(flush_req), .flush_done(flush_done), .busy(busy),
        .hp_enable(hp_enable), .hp_operation(hp_operation), .hp_input_value(hp_input_value),
        .hp_index(hp_index), .hp_output_value(hp_output_value), .hp_heap_size(hp_heap_size)
    );

    // Behavioural max-heap standing in for heap_module.
    logic [DATA_W-1:0] hmem [0:31];
    int hcnt;
    int hmax_idx;
    always_comb begin
        hmax_idx = 0;
        for (int i = 1; i < 32; i++)
            if (i < hcnt && hmem[i] > hmem[hmax_idx]) hmax_idx = i;
    end
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            hcnt            <= 0;
            hp_output_value <= '0;
        end else begin
            hp_output_value <= (hcnt > 0) ? hmem[hmax_idx] : '0;
            if (hp_enable) begin
                case (hp_operation)
                    HP_OP_INIT: hcnt <= 0;
                    HP_OP_PUSH: begin
                        hmem[hcnt] <= hp_input_value;
                        hcnt       <= hcnt + 1;
                    end
                    HP_OP_POP: if (hcnt > 0) begin
                        hmem[hmax_idx] <= hmem[hcnt-1];
                        hcnt           <= hcnt - 1;
                    end
                    default: ;
                endcase
            end
        end
    end
    assign hp_heap_size = SIZE_W'(hcnt);

    typedef struct {
        int                client;
        logic              op;
        logic [DATA_W-1:0] pval;
        logic              err;
        logic [DATA_W-1:0] data;
        int                t;
        int                lat;
    } exp_t;

    exp_t              sb[$];
    logic [DATA_W-1:0] ref_q[$];
    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int last_cmd_cyc = -100;
    logic [4:0] last_cmd_op = '0;
    logic [DATA_W-1:0] last_cmd_val = '0;
    int cmd_count = 0;
    int last_rsp_cyc = -100;
    logic [DATA_W-1:0] mon_last_data = '0;
    logic mon_last_err = 1'b0;
    exp_t mon_e;
    logic [NREQ-1:0] mon_oh;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Response monitor: pops the scoreboard on every rsp_valid.
    initial forever begin
        @(negedge clk);
        if (!reset && hp_enable) begin
            last_cmd_cyc = cyc;
            last_cmd_op  = hp_operation;
            last_cmd_val = hp_input_value;
            cmd_count++;
        end
        if (!reset && rsp_valid != '0) begin
            last_rsp_cyc  = cyc;
            mon_last_data = rsp_data;
            mon_last_err  = rsp_err;
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_rsp: rsp_valid=%b, no request pending", rsp_valid);
            end else begin
                mon_e = sb.pop_front();
                mon_oh = '0;
                mon_oh[mon_e.client] = 1'b1;
                if (rsp_valid !== mon_oh) begin
                    errors++;
                    $display("FAIL rsp_onehot: got %b expected %b", rsp_valid, mon_oh);
                end
                checks++;
                if (rsp_err !== mon_e.err) begin
                    errors++;
                    $display("FAIL rsp_err: got %b expected %b", rsp_err, mon_e.err);
                end
                checks++;
                if (rsp_data !== mon_e.data) begin
                    errors++;
                    $display("FAIL rsp_data: got %h expected %h", rsp_data, mon_e.data);
                end
                checks++;
                if (cyc - mon_e.t != mon_e.lat) begin
                    errors++;
                    $display("FAIL rsp_latency: got %0d expected %0d", cyc - mon_e.t, mon_e.lat);
                end
                checks++;
                if (mon_e.err) begin
                    if (last_cmd_cyc >= mon_e.t) begin
                        errors++;
                        $display("FAIL err_no_cmd: heap command at cycle %0d, expected none after %0d", last_cmd_cyc, mon_e.t);
                    end
                end else begin
                    if (last_cmd_cyc != cyc - 1 ||
                        last_cmd_op !== (mon_e.op ? HP_OP_POP : HP_OP_PUSH) ||
                        (!mon_e.op && last_cmd_val !== mon_e.pval)) begin
                        errors++;
                        $display("FAIL heap_cmd: got cyc=%0d op=%0d val=%h expected cyc=%0d op=%0d val=%h",
                                 last_cmd_cyc, last_cmd_op, last_cmd_val, cyc - 1,
                                 mon_e.op ? HP_OP_POP : HP_OP_PUSH, mon_e.pval);
                    end
                end
            end
        end
    end

    function automatic void sb_push(input int c, input logic op, input logic [DATA_W-1:0] d);
        exp_t e;
        int m;
        e.client = c; e.op = op; e.pval = d; e.t = cyc; e.err = 1'b0; e.data = '0; e.lat = 0;
        m = 0;
        if (op == CLIENT_OP_PUSH) begin
            if (ref_q.size() >= CAP) begin e.err = 1'b1; e.lat = 2; end
            else begin ref_q.push_back(d); e.lat = 3; end
        end else if (ref_q.size() == 0) begin
            e.err = 1'b1; e.lat = 2;
        end else begin
            for (int i = 1; i < ref_q.size(); i++) if (ref_q[i] > ref_q[m]) m = i;
            e.data = ref_q[m];
            ref_q.delete(m);
            e.lat = 4;
        end
        sb.push_back(e);
    endfunction

    task automatic wait_idle();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 40) begin
            @(posedge clk);
            n++;
        end
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL rsp_timeout: %0d responses outstanding, expected 0", sb.size());
            sb.delete();
        end
    endtask

    task automatic do_req(input int c, input logic op, input logic [DATA_W-1:0] d, input bit wait_rsp);
        int n;
        @(negedge clk);
        req_valid[c] = 1'b1;
        req_op[c]    = op;
        req_data[c*DATA_W +: DATA_W] = d;
        #1;
        n = 0;
        while (!req_ready[c] && n < 50) begin
            @(negedge clk); #1;
            n++;
        end
        checks++;
        if (!req_ready[c]) begin
            errors++;
            $display("FAIL accept_timeout: client %0d req_ready=%b, expected bit set", c, req_ready);
            req_valid[c] = 1'b0;
            return;
        end
        sb_push(c, op, d);
        @(posedge clk); #1;
        req_valid[c] = 1'b0;
        if (wait_rsp) wait_idle();
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        reset = 1'b1;
        sb.delete();
        ref_q.delete();
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic check_outputs_zero(input string tag);
        checks++;
        if ({req_ready, rsp_valid, rsp_data, rsp_err, flush_done, busy, hp_enable,
             hp_operation, hp_input_value, hp_index} !== '0) begin
            errors++;
            $display("FAIL %s: outputs rdy=%b rv=%b rd=%h re=%b fd=%b bz=%b en=%b op=%0d iv=%h ix=%0d, expected all 0",
                     tag, req_ready, rsp_valid, rsp_data, rsp_err, flush_done, busy, hp_enable,
                     hp_operation, hp_input_value, hp_index);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; req_valid = '0; req_op = '0; req_data = '0; flush_req = 1'b0;
        repeat (2) @(negedge clk);
        check_outputs_zero("reset_held");
        reset = 1'b0;
        @(negedge clk);
        check_outputs_zero("reset_released");
    endtask

    task automatic test_push_pop();
        do_req(0, CLIENT_OP_PUSH, 32'h10, 1'b1);
        do_req(1, CLIENT_OP_PUSH, 32'h30, 1'b1);
        do_req(2, CLIENT_OP_POP, 32'h0, 1'b1);
        checks++;
        if (mon_last_data !== 32'h30 || mon_last_err !== 1'b0) begin
            errors++;
            $display("FAIL push_pop_value: got %h err=%b expected 00000030 err=0", mon_last_data, mon_last_err);
        end
        @(negedge clk);
        checks++;
        if (hp_heap_size !== 5'd1) begin
            errors++;
            $display("FAIL push_pop_size: got %0d expected 1", hp_heap_size);
        end
    endtask

    task automatic test_round_robin();
        int exp_order[5] = '{0, 1, 2, 3, 0};
        logic [NREQ-1:0] exp_oh;
        int got, n, w;
        // Brings ptr back to 0 and leaves six entries in the heap.
        do_req(3, CLIENT_OP_PUSH, 32'h21, 1'b1);
        do_req(0, CLIENT_OP_PUSH, 32'h05, 1'b1);
        do_req(1, CLIENT_OP_PUSH, 32'h44, 1'b1);
        do_req(2, CLIENT_OP_PUSH, 32'h17, 1'b1);
        do_req(3, CLIENT_OP_PUSH, 32'h08, 1'b1);
        @(negedge clk);
        req_op = '1;
        req_valid = '1;
        got = 0; n = 0;
        while (got < 5 && n < 200) begin
            #1;
            if (req_ready != '0) begin
                exp_oh = '0;
                exp_oh[exp_order[got]] = 1'b1;
                checks++;
                if (req_ready !== exp_oh) begin
                    errors++;
                    $display("FAIL rr_grant%0d: got %b expected %b", got, req_ready, exp_oh);
                end
                w = 0;
                for (int i = NREQ - 1; i >= 0; i--) if (req_ready[i]) w = i;
                sb_push(w, CLIENT_OP_POP, '0);
                got++;
                if (got == 5) begin
                    @(posedge clk); #1;
                    req_valid = '0;
                end
            end
            @(negedge clk);
            n++;
        end
        req_valid = '0;
        req_op = '0;
        checks++;
        if (got != 5) begin
            errors++;
            $display("FAIL rr_count: got %0d grants expected 5", got);
        end
        wait_idle();
    endtask

    task automatic test_empty_pop();
        int c0;
        pulse_reset();
        c0 = cmd_count;
        do_req(1, CLIENT_OP_POP, '0, 1'b1);
        checks++;
        if (mon_last_err !== 1'b1 || mon_last_data !== '0 || cmd_count != c0) begin
            errors++;
            $display("FAIL empty_pop: got err=%b data=%h cmds=%0d expected err=1 data=0 cmds=0",
                     mon_last_err, mon_last_data, cmd_count - c0);
        end
    endtask

    task automatic test_full();
        for (int i = 0; i < CAP; i++) do_req(i % NREQ, CLIENT_OP_PUSH, $urandom, 1'b1);
        do_req(0, CLIENT_OP_PUSH, 32'hdead, 1'b1);
        @(negedge clk);
        checks++;
        if (mon_last_err !== 1'b1 || hp_heap_size !== 5'd31) begin
            errors++;
            $display("FAIL full_push: got err=%b size=%0d expected err=1 size=31", mon_last_err, hp_heap_size);
        end
    endtask

    task automatic test_flush();
        int n;
        do_req(2, CLIENT_OP_POP, '0, 1'b0);
        flush_req = 1'b1;
        n = 0;
        while (!flush_done && n < 40) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (!flush_done) begin
            errors++;
            $display("FAIL flush_timeout: flush_done=%b expected 1", flush_done);
        end else begin
            checks++;
            if (sb.size() != 0 || cyc - last_rsp_cyc != 3) begin
                errors++;
                $display("FAIL flush_order: pending=%0d gap=%0d expected pending=0 gap=3", sb.size(), cyc - last_rsp_cyc);
            end
            checks++;
            if (last_cmd_op !== HP_OP_INIT || last_cmd_cyc != cyc - 1) begin
                errors++;
                $display("FAIL flush_cmd: got op=%0d cyc=%0d expected op=0 cyc=%0d", last_cmd_op, last_cmd_cyc, cyc - 1);
            end
        end
        flush_req = 1'b0;
        ref_q.delete();
        sb.delete();
        @(negedge clk);
        checks++;
        if (flush_done !== 1'b0 || hp_heap_size !== '0) begin
            errors++;
            $display("FAIL flush_after: got done=%b size=%0d expected done=0 size=0", flush_done, hp_heap_size);
        end
        do_req(3, CLIENT_OP_POP, '0, 1'b1);
        checks++;
        if (mon_last_err !== 1'b1) begin
            errors++;
            $display("FAIL flush_pop_err: got %b expected 1", mon_last_err);
        end
    endtask

    task automatic test_reset_mid_pop();
        int n;
        do_req(3, CLIENT_OP_PUSH, 32'h77, 1'b1);
        @(negedge clk);
        req_valid[1] = 1'b1;
        req_op[1] = CLIENT_OP_POP;
        #1;
        n = 0;
        while (!req_ready[1] && n < 20) begin
            @(negedge clk); #1;
            n++;
        end
        checks++;
        if (!req_ready[1]) begin
            errors++;
            $display("FAIL midpop_accept: req_ready=%b expected bit 1 set", req_ready);
        end
        @(posedge clk); #1;
        req_valid[1] = 1'b0;
        req_op[1] = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        sb.delete();
        ref_q.delete();
        #1;
        check_outputs_zero("midpop_reset");
        repeat (3) begin
            @(negedge clk);
            checks++;
            if (rsp_valid !== '0 || hp_enable !== 1'b0) begin
                errors++;
                $display("FAIL midpop_quiet: rsp_valid=%b hp_enable=%b expected 0", rsp_valid, hp_enable);
            end
        end
        reset = 1'b0;
        repeat (3) @(negedge clk);
        req_op = '0;
        req_data = {32'h4, 32'h3, 32'h2, 32'h1};
        req_valid = '1;
        #1;
        checks++;
        if (req_ready !== 4'b0001) begin
            errors++;
            $display("FAIL midpop_first_grant: got %b expected 0001", req_ready);
        end else begin
            sb_push(0, CLIENT_OP_PUSH, 32'h1);
        end
        @(posedge clk); #1;
        req_valid = '0;
        wait_idle();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_push_pop();
        test_round_robin();
        test_empty_pop();
        test_full();
        test_flush();
        test_reset_mid_pop();
        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
